rtc_timekeeper: RTL and testbench

//  Fully synchronous time-of-day counter (hh:mm:ss) driven from the system clock.
//  Has an internal 1 Hz prescaler and a RUN/SET mode machine with edge-detected set buttons.

---
 rtl/clock_pkg.sv | 31 +++
 rtl/tick_gen.sv | 39 +++
 rtl/rtc_timekeeper.sv | 118 +++++++++++
 tb/tb_rtc_timekeeper.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types, field widths and limits for the time-of-day counter.
// Also provides the 24-h to 12-h display conversion.
package clock_pkg;

  typedef enum logic {CLK_SET, CLK_RUN} tmod_t;

  localparam int unsigned SEC_W    = 6;
  localparam int unsigned MIN_W    = 6;
  localparam int unsigned HR_W     = 5;

  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HR_MAX   = 23;
  localparam int unsigned HALF_DAY = 12;

  // Returns {pm, hr12}: 0 -> 12 AM, 12 -> 12 PM, 13..23 -> 1..11 PM.
  function automatic logic [HR_W:0] to_12h(input logic [HR_W-1:0] hr24);
    logic            pm;
    logic [HR_W-1:0] h12;
    pm = (hr24 >= HR_W'(HALF_DAY));
    if ((hr24 == '0) || (hr24 == HR_W'(HALF_DAY))) begin
      h12 = HR_W'(HALF_DAY);
    end else if (pm) begin
      h12 = hr24 - HR_W'(HALF_DAY);
    end else begin
      h12 = hr24;
    end
    return {pm, h12};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// 1 Hz prescaler: counts 0..CLK_HZ-1 while enabled, pulses tick on the last count.
// Held at zero whenever enable is low so the first tick lands CLK_HZ cycles after enabling.
module tick_gen #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CTR_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CTR_W-1:0] CNT_MAX = CTR_W'(CLK_HZ - 1);

  logic [CTR_W-1:0] count_q;
  logic [CTR_W-1:0] count_d;
  logic             wrap;

  assign wrap = (count_q == CNT_MAX);
  assign tick = enable & wrap;

  always_comb begin
    count_d = count_q;
    if (!enable || wrap) begin
      count_d = '0;
    end else begin
      count_d = count_q + CTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rtc_timekeeper.sv
// hh:mm:ss time-of-day counter with RUN/SET mode, edge-detected set buttons,
// 12/24-hour display mapping and a single-cycle alarm pulse.
module rtc_timekeeper
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_toggle,
  input  logic              set_min,
  input  logic              set_hr,
  input  logic              mode_12h,
  input  logic              alarm_en,
  input  logic [HR_W-1:0]   alarm_hr,
  input  logic [MIN_W-1:0]  alarm_min,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HR_W-1:0]   hr,
  output logic              pm,
  output logic              running,
  output logic              tick_1hz,
  output logic              alarm_hit
);

  tmod_t             mode_q;
  logic              rt_q, sm_q, sh_q;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic [MIN_W-1:0]  min_q, min_d;
  logic [HR_W-1:0]   hr_q, hr_d;
  logic              alarm_q, alarm_d;
  logic              rt_stb, sm_stb, sh_stb;
  logic              tick;
  logic [HR_W:0]     disp12;

  tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .enable (mode_q == CLK_RUN),
    .tick   (tick)
  );

  // Set strobes coinciding with a mode toggle are dropped.
  assign rt_stb = run_toggle & ~rt_q;
  assign sm_stb = set_min & ~sm_q & ~rt_stb;
  assign sh_stb = set_hr & ~sh_q & ~rt_stb;

  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    hr_d  = hr_q;
    if (mode_q == CLK_RUN) begin
      if (tick) begin
        if (sec_q == SEC_W'(SEC_MAX)) begin
          sec_d = '0;
          if (min_q == MIN_W'(MIN_MAX)) begin
            min_d = '0;
            hr_d  = (hr_q == HR_W'(HR_MAX)) ? '0 : hr_q + HR_W'(1);
          end else begin
            min_d = min_q + MIN_W'(1);
          end
        end else begin
          sec_d = sec_q + SEC_W'(1);
        end
      end
    end else begin
      if (sm_stb) begin
        sec_d = '0;
        min_d = (min_q == MIN_W'(MIN_MAX)) ? '0 : min_q + MIN_W'(1);
      end
      if (sh_stb) begin
        hr_d = (hr_q == HR_W'(HR_MAX)) ? '0 : hr_q + HR_W'(1);
      end
    end
  end

  // Alarm is judged on the time a tick produces, so SET edits never fire it.
  always_comb begin
    alarm_d = (mode_q == CLK_RUN) && tick && alarm_en &&
              (hr_d == alarm_hr) && (min_d == alarm_min) && (sec_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= CLK_SET;
      rt_q    <= 1'b0;
      sm_q    <= 1'b0;
      sh_q    <= 1'b0;
      sec_q   <= '0;
      min_q   <= '0;
      hr_q    <= '0;
      alarm_q <= 1'b0;
    end else begin
      rt_q    <= run_toggle;
      sm_q    <= set_min;
      sh_q    <= set_hr;
      if (rt_stb) begin
        mode_q <= (mode_q == CLK_SET) ? CLK_RUN : CLK_SET;
      end
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      alarm_q <= alarm_d;
    end
  end

  assign disp12    = to_12h(hr_q);
  assign hr        = mode_12h ? disp12[HR_W-1:0] : hr_q;
  assign pm        = mode_12h & disp12[HR_W];
  assign sec       = sec_q;
  assign min       = min_q;
  assign running   = (mode_q == CLK_RUN);
  assign tick_1hz  = tick;
  assign alarm_hit = alarm_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Randomized and directed bench for rtc_timekeeper; a seconds-of-day reference model
// feeds a scoreboard queue that a separate monitor drains every cycle.
module tb_rtc_timekeeper;

  localparam int unsigned HZ = 4;
  localparam int DAY = 86400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run_toggle = 1'b0;
  logic       set_min = 1'b0;
  logic       set_hr = 1'b0;
  logic       mode_12h = 1'b0;
  logic       alarm_en = 1'b0;
  logic [4:0] alarm_hr = 5'd0;
  logic [5:0] alarm_min = 6'd0;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hr;
  logic       pm, running, tick_1hz, alarm_hit;

  always #5 clk = ~clk;

  rtc_timekeeper #(.CLK_HZ(HZ)) dut (
    .clk        (clk),
    .rst        (rst),
    .run_toggle (run_toggle),
    .set_min    (set_min),
    .set_hr     (set_hr),
    .mode_12h   (mode_12h),
    .alarm_en   (alarm_en),
    .alarm_hr   (alarm_hr),
    .alarm_min  (alarm_min),
    .sec        (sec),
    .min        (min),
    .hr         (hr),
    .pm         (pm),
    .running    (running),
    .tick_1hz   (tick_1hz),
    .alarm_hit  (alarm_hit)
  );

  typedef struct {
    int sec; int min; int hr; int pm; int run; int tick; int alarm;
  } exp_t;

  exp_t sb[$];

  // Reference model: time kept as seconds since midnight.
  int m_tod, m_presc, m_alarm;
  bit m_run, p_rt, p_sm, p_sh;

  int  checks = 0;
  int  errors = 0;
  bit  done = 1'b0;

  task automatic model_reset();
    m_tod = 0; m_presc = 0; m_alarm = 0; m_run = 0;
    p_rt = 0; p_sm = 0; p_sh = 0;
  endtask

  task automatic model_edge();
    bit rt, sm, sh, tk;
    int h, m, s;
    if (rst) begin
      model_reset();
      return;
    end
    rt = run_toggle && !p_rt;
    sm = set_min && !p_sm && !rt;
    sh = set_hr && !p_sh && !rt;
    p_rt = run_toggle; p_sm = set_min; p_sh = set_hr;
    m_alarm = 0;
    if (m_run) begin
      tk = (m_presc == int'(HZ) - 1);
      m_presc = tk ? 0 : m_presc + 1;
      if (tk) begin
        m_tod = (m_tod + 1) % DAY;
        if (alarm_en && int'(alarm_hr) < 24 && int'(alarm_min) < 60 &&
            m_tod == int'(alarm_hr) * 3600 + int'(alarm_min) * 60)
          m_alarm = 1;
      end
    end else begin
      m_presc = 0;
      h = m_tod / 3600; m = (m_tod / 60) % 60; s = m_tod % 60;
      if (sm) begin m = (m + 1) % 60; s = 0; end
      if (sh) h = (h + 1) % 24;
      m_tod = h * 3600 + m * 60 + s;
    end
    if (rt) m_run = !m_run;
  endtask

  function automatic exp_t snap();
    exp_t e;
    int h24;
    h24 = m_tod / 3600;
    e.sec   = m_tod % 60;
    e.min   = (m_tod / 60) % 60;
    e.hr    = mode_12h ? (((h24 % 12) == 0) ? 12 : h24 % 12) : h24;
    e.pm    = (mode_12h && h24 >= 12) ? 1 : 0;
    e.run   = m_run ? 1 : 0;
    e.tick  = (m_run && m_presc == int'(HZ) - 1) ? 1 : 0;
    e.alarm = m_alarm;
    return e;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      sb.push_back(snap());
      @(negedge clk);
    end
  endtask

  task automatic tap_run();
    run_toggle = 1'b1; cyc(1); run_toggle = 1'b0; cyc(1);
  endtask

  task automatic tap_min();
    set_min = 1'b1; cyc(1); set_min = 1'b0; cyc(1);
  endtask

  task automatic tap_hr();
    set_hr = 1'b1; cyc(1); set_hr = 1'b0; cyc(1);
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
  endtask

  // Stimulus
  initial begin
    model_reset();
    @(negedge clk);
    cyc(3);
    rst = 1'b0;
    cyc(1);
    // reset pulse while the prescaler is mid-count, then idle
    tap_run();
    cyc(7);
    rst = 1'b1; cyc(2); rst = 1'b0;
    cyc(20);
    // run from reset through the first minute carry
    tap_run();
    cyc(244);
    // midnight wrap from 23:59:00, shown in 12-h mode
    do_reset();
    repeat (23) tap_hr();
    repeat (59) tap_min();
    mode_12h = 1'b1;
    tap_run();
    cyc(248);
    // held button, minute wrap without carry, toggle+set collision
    do_reset();
    mode_12h = 1'b0;
    set_min = 1'b1; cyc(10); set_min = 1'b0; cyc(2);
    repeat (58) tap_min();
    tap_min();
    set_hr = 1'b1; run_toggle = 1'b1; cyc(1);
    set_hr = 1'b0; run_toggle = 1'b0; cyc(6);
    // alarm at 01:00, enabled then disabled
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      alarm_hr = 5'd1; alarm_min = 6'd0; alarm_en = (pass == 0);
      repeat (59) tap_min();
      tap_run();
      cyc(58 * 4 - 1);
      cyc(16);
    end
    // 12-h sweep over all hours, then mode flips
    do_reset();
    mode_12h = 1'b1;
    repeat (24) tap_hr();
    for (int k = 0; k < 6; k++) begin
      mode_12h = ~mode_12h; cyc(1);
      tap_hr();
    end
    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      run_toggle = ($urandom_range(0, 40) == 0);
      set_min    = ($urandom_range(0, 3) == 0);
      set_hr     = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 30) == 0) mode_12h = ~mode_12h;
      if ($urandom_range(0, 20) == 0) alarm_en = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 40) == 0) begin
        if ($urandom_range(0, 4) == 0) begin
          alarm_hr  = 5'($urandom_range(0, 31));
          alarm_min = 6'($urandom_range(0, 63));
        end else begin
          alarm_hr  = 5'(m_tod / 3600);
          alarm_min = 6'(((m_tod / 60) + 1) % 60);
        end
      end
      rst = ($urandom_range(0, 700) == 0);
      cyc(1);
    end
    rst = 1'b0; run_toggle = 1'b0; set_min = 1'b0; set_hr = 1'b0;
    cyc(2);
    done = 1'b1;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sec",       int'(sec),       e.sec);
        chk("min",       int'(min),       e.min);
        chk("hr",        int'(hr),        e.hr);
        chk("pm",        int'(pm),        e.pm);
        chk("running",   int'(running),   e.run);
        chk("tick_1hz",  int'(tick_1hz),  e.tick);
        chk("alarm_hit", int'(alarm_hit), e.alarm);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
